// File: rtl/uart_defs.sv
// Shared UART definitions: frame widths, receiver FSM state encodings and the
// baud divider calculation used by both receive and transmit paths.
package uart_defs;

  localparam int FRAME_W = 9;
  localparam int DATA_W  = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
module uart_baud_tick
  import uart_defs::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV_RAW = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With DIV==1 the counter sits at zero and tick is permanently high.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: 16x oversampled, mid-bit sampled 8 data + 1 parity bit frames
// with parity and framing error reporting. state_dbg exposes the FSM state.
module uart_rx_framer
  import uart_defs::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [FRAME_W-1:0]   frame,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

  logic                tick;
  logic                sync1_q, sync2_q;
  logic                rxs;
  logic [2:0]          state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                fv_q, fv_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rxs = sync2_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    frame_d = frame_q;
    busy_d  = busy_q;
    fv_d    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          tcnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == T_HALF) begin
            // Still low at mid start bit: a real start, otherwise a glitch.
            if (!rxs) begin
              state_d = ST_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            shift_d[bcnt_q] = rxs;
            bcnt_d          = bcnt_q + 1'b1;
            tcnt_d          = '0;
            if (bcnt_q == 3'd7) state_d = ST_PARITY;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            shift_d[FRAME_W-1] = rxs;
            tcnt_d             = '0;
            state_d            = ST_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            busy_d = 1'b0;
            if (rxs) begin
              frame_d = shift_q;
              fv_d    = 1'b1;
              perr_d  = (^shift_q) ^ PARITY_ODD;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // A held-low line must go high before another start is looked for.
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer at 1 Mbaud / 16 MHz (one bit = 16 clk).
module tb_uart_rx_framer;
  import uart_defs::*;

  localparam int  CLK_HZ  = 16_000_000;
  localparam int  BAUD    = 1_000_000;
  localparam int  OS      = 16;
  localparam int  BIT_CLK = 16;
  localparam bit  P_ODD   = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [8:0] frame;
  logic       frame_valid, parity_err, framing_err, busy;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .PARITY_ODD (P_ODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .frame       (frame),
    .frame_valid (frame_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  typedef struct {
    int unsigned cyc;
    logic        fv;
    logic        ferr;
    logic        perr;
    logic        busy;
    logic [8:0]  frame;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [8:0] exp_frame;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  obs_t        got_q[$];
  logic [11:0] exp_q[$];
  int unsigned cyc = 0;
  int          vec_cnt = 0;
  int          miscompares = 0;

  // Monitor: one record per clock in which any strobe is high.
  always @(negedge clk) begin : mon
    obs_t o;
    cyc = cyc + 1;
    if (rst && (frame_valid || framing_err || parity_err)) begin
      o.cyc   = cyc;
      o.fv    = frame_valid;
      o.ferr  = framing_err;
      o.perr  = parity_err;
      o.busy  = busy;
      o.frame = frame;
      got_q.push_back(o);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = par;
    repeat (BIT_CLK) @(negedge clk);
    rx = stop;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " frame"}, frame, 0);
    check({tag, " frame_valid"}, frame_valid, 0);
    check({tag, " parity_err"}, parity_err, 0);
    check({tag, " framing_err"}, framing_err, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " state"}, state_dbg, ST_IDLE);
  endtask

  vec_t        tbl[6];
  obs_t        o;
  logic [8:0]  model_frame;
  logic [11:0] e;
  logic        busy_seen;
  logic [7:0]  rd;
  logic        rp, rs;
  int          n_rand;

  initial begin
    tbl[0] = '{8'hAA, 1'b0, 1'b1, 9'h0AA, 1'b0, 1'b0};
    tbl[1] = '{8'hB3, 1'b0, 1'b1, 9'h0B3, 1'b1, 1'b0};
    tbl[2] = '{8'hB3, 1'b1, 1'b1, 9'h1B3, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 9'h1FF, 1'b1, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 9'h1FF, 1'b0, 1'b1};

    // Clock/reset
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
      if (!tbl[i].stop) rx = 1'b1;
      wait_obs(1, 64);
      repeat (20) @(negedge clk);
      check($sformatf("tbl%0d strobe count", i), got_q.size(), 1);
      if (got_q.size() > 0) begin
        o = got_q[0];
        check($sformatf("tbl%0d frame_valid", i), o.fv, !tbl[i].exp_ferr);
        check($sformatf("tbl%0d framing_err", i), o.ferr, tbl[i].exp_ferr);
        check($sformatf("tbl%0d parity_err", i), o.perr, tbl[i].exp_perr);
        check($sformatf("tbl%0d frame", i), o.frame, tbl[i].exp_frame);
        check($sformatf("tbl%0d busy at strobe", i), o.busy, 0);
      end
      check($sformatf("tbl%0d frame hold", i), frame, tbl[i].exp_frame);
      check($sformatf("tbl%0d idle state", i), state_dbg, ST_IDLE);
    end

    // Short low glitch on idle line
    got_q.delete();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("glitch busy", busy_seen, 0);
    check("glitch strobes", got_q.size(), 0);
    check("glitch state", state_dbg, ST_IDLE);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_obs(1, 64);
    check("after glitch count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("after glitch frame", got_q[0].frame, 9'h055);
      check("after glitch perr", got_q[0].perr, 0);
    end

    // Bad stop bit followed by a 40-bit line break
    got_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    busy_seen = 1'b0;
    for (int i = 0; i < 40 * BIT_CLK; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("break busy", busy_seen, 0);
    check("break state", state_dbg, ST_BREAK);
    check("break strobe count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("break framing_err", got_q[0].ferr, 1);
      check("break frame_valid", got_q[0].fv, 0);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break release state", state_dbg, ST_IDLE);
    check("break release count", got_q.size(), 1);
    check("break frame kept", frame, 9'h055);

    // Back-to-back frames, no idle gap
    got_q.delete();
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_obs(2, 64);
    check("b2b count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("b2b frame0", got_q[0].frame, 9'h001);
      check("b2b frame1", got_q[1].frame, 9'h1FF);
      check("b2b spacing", got_q[1].cyc - got_q[0].cyc, 11 * BIT_CLK);
    end

    // Reset pulse in the middle of data bit 4
    got_q.delete();
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    check("pre-reset busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe reset");
    rst = 1'b1;
    rx  = 1'b1;
    repeat (40) @(negedge clk);
    check("post-reset strobes", got_q.size(), 0);
    send_frame(8'hC5, 1'b0, 1'b1);
    wait_obs(1, 64);
    check("post-reset count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("post-reset frame", got_q[0].frame, 9'h0C5);
      check("post-reset perr", got_q[0].perr, 0);
    end
    repeat (5) @(negedge clk);

    // Randomized frames against the reference model
    got_q.delete();
    exp_q.delete();
    model_frame = 9'h0C5;
    n_rand = 24;
    for (int k = 0; k < n_rand; k++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 5) != 0);
      if (rs) begin
        model_frame = {rp, rd};
        exp_q.push_back({1'b1, 1'b0,
                         1'((($countones({rp, rd}) % 2) == 1) != P_ODD),
                         rp, rd});
      end else begin
        exp_q.push_back({1'b0, 1'b1, 1'b0, model_frame});
      end
      send_frame(rd, rp, rs);
      if (!rs) begin
        rx = 1'b1;
        repeat ($urandom_range(4, 12)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    wait_obs(n_rand, 400);
    repeat (5) @(negedge clk);
    check("random strobe count", got_q.size(), n_rand);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      o = got_q.pop_front();
      e = exp_q.pop_front();
      check("random obs {fv,ferr,perr,frame}", {o.fv, o.ferr, o.perr, o.frame}, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
